// File: rtl/mouse_pkg.sv
// Shared definitions for the mouse-pointer core: bus register map, STATUS layout
// and the sprite-fill state type.
package mouse_pkg;

  localparam int unsigned BUS_WIDTH = 32;

  localparam logic [1:0] REG_PTR  = 2'd0;
  localparam logic [1:0] REG_DATA = 2'd1;
  localparam logic [1:0] REG_FILL = 2'd2;
  localparam logic [1:0] REG_CTRL = 2'd3;

  localparam int unsigned STAT_BUSY_BIT = 0;
  localparam int unsigned STAT_OVR_BIT  = 1;
  localparam int unsigned STAT_PTR_LSB  = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } fill_state_t;

endpackage

// File: rtl/mouse_ram_loader.sv
// Bus-to-sprite-RAM writer with auto-incrementing pointer; the hardware fill
// engine is built only when MOUSE_LOADER_FILL_EN is defined.
module mouse_ram_loader
  import mouse_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 12,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cs,
  input  logic                  write,
  input  logic                  read,
  input  logic [1:0]            addr,
  input  logic [BUS_WIDTH-1:0]  wr_data,
  output logic [BUS_WIDTH-1:0]  rd_data,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr_w,
  output logic [DATA_WIDTH-1:0] ram_din
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;

  logic                  w_bus_wr;
  logic                  w_wr_ptr;
  logic                  w_wr_data;
  logic                  w_wr_fill;
  logic                  w_wr_ctrl;
  logic                  w_busy;
  logic                  w_set_ovr;
  logic                  w_fill_start;
  logic                  w_fill_step;
  logic [ADDR_WIDTH-1:0] w_fill_addr;
  logic [DATA_WIDTH-1:0] w_fill_color;
  logic                  w_unused;

  logic [ADDR_WIDTH-1:0] r_ptr;
  logic                  r_overrun;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_din;

  assign w_bus_wr  = cs & write;
  assign w_wr_ptr  = w_bus_wr & (addr == REG_PTR);
  assign w_wr_data = w_bus_wr & (addr == REG_DATA);
  assign w_wr_fill = w_bus_wr & (addr == REG_FILL);
  assign w_wr_ctrl = w_bus_wr & (addr == REG_CTRL);

  // STATUS is not gated by read; the bus slot adds its own read latency
  assign w_unused = ^{read, wr_data, w_wr_fill};

`ifdef MOUSE_LOADER_FILL_EN
  fill_state_t           r_state;
  fill_state_t           w_state_next;
  logic [ADDR_WIDTH-1:0] r_fill_cnt;
  logic [DATA_WIDTH-1:0] r_color;

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_wr_fill) w_state_next = ST_FILL;
      ST_FILL: if (r_fill_cnt == ADDR_LAST) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // r_fill_cnt tracks the address currently presented on the RAM port
  always_comb begin
    w_busy       = 1'b0;
    w_fill_start = 1'b0;
    w_fill_step  = 1'b0;
    w_set_ovr    = 1'b0;
    case (r_state)
      ST_IDLE: w_fill_start = w_wr_fill;
      ST_FILL: begin
        w_busy      = 1'b1;
        w_fill_step = (r_fill_cnt != ADDR_LAST);
        w_set_ovr   = w_wr_ptr | w_wr_data | w_wr_fill;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_fill_cnt <= '0;
      r_color    <= '0;
    end else if (w_fill_start) begin
      r_fill_cnt <= '0;
      r_color    <= wr_data[DATA_WIDTH-1:0];
    end else if (w_busy) begin
      r_fill_cnt <= r_fill_cnt + ADDR_WIDTH'(1);
    end
  end

  assign w_fill_addr  = r_fill_cnt + ADDR_WIDTH'(1);
  assign w_fill_color = r_color;
`else
  assign w_busy       = 1'b0;
  assign w_fill_start = 1'b0;
  assign w_fill_step  = 1'b0;
  assign w_set_ovr    = 1'b0;
  assign w_fill_addr  = '0;
  assign w_fill_color = '0;
`endif

  // Pointer, overrun flag and registered RAM write port
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_ptr     <= '0;
      r_overrun <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_din     <= '0;
    end else begin
      r_we <= 1'b0;
      if (w_fill_start) begin
        r_we   <= 1'b1;
        r_addr <= '0;
        r_din  <= wr_data[DATA_WIDTH-1:0];
      end else if (w_fill_step) begin
        r_we   <= 1'b1;
        r_addr <= w_fill_addr;
        r_din  <= w_fill_color;
      end else if (w_wr_data && !w_busy) begin
        r_we   <= 1'b1;
        r_addr <= r_ptr;
        r_din  <= wr_data[DATA_WIDTH-1:0];
      end

      if (!w_busy) begin
        if (w_wr_ptr)       r_ptr <= wr_data[ADDR_WIDTH-1:0];
        else if (w_wr_data) r_ptr <= r_ptr + ADDR_WIDTH'(1);
      end

      if (w_wr_ctrl)      r_overrun <= 1'b0;
      else if (w_set_ovr) r_overrun <= 1'b1;
    end
  end

  always_comb begin
    rd_data                                = '0;
    rd_data[STAT_BUSY_BIT]                 = w_busy;
    rd_data[STAT_OVR_BIT]                  = r_overrun;
    rd_data[STAT_PTR_LSB +: ADDR_WIDTH]    = r_ptr;
  end

  assign ram_we     = r_we;
  assign ram_addr_w = r_addr;
  assign ram_din    = r_din;

endmodule

// File: tb/tb_mouse_ram_loader.sv
// Self-checking bench for mouse_ram_loader; tracks expected RAM writes with a
// cycle-stamped queue model. Fill tests run when MOUSE_LOADER_FILL_EN is defined.
module tb_mouse_ram_loader;

  localparam int AW    = 10;
  localparam int DW    = 12;
  localparam int DEPTH = 1 << AW;
`ifdef MOUSE_LOADER_FILL_EN
  localparam bit FILL_EN = 1'b1;
`else
  localparam bit FILL_EN = 1'b0;
`endif

  logic          clk     = 1'b0;
  logic          reset_n = 1'b0;
  logic          cs      = 1'b0;
  logic          write   = 1'b0;
  logic          read    = 1'b0;
  logic [1:0]    addr    = 2'd0;
  logic [31:0]   wr_data = 32'd0;
  logic [31:0]   rd_data;
  logic          ram_we;
  logic [AW-1:0] ram_addr_w;
  logic [DW-1:0] ram_din;

  mouse_ram_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset_n(reset_n), .cs(cs), .write(write), .read(read),
    .addr(addr), .wr_data(wr_data), .rd_data(rd_data),
    .ram_we(ram_we), .ram_addr_w(ram_addr_w), .ram_din(ram_din)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int            cyc;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t exp_q[$];
  wr_t obs_q[$];
  int  cyc = 0;
  int  n_chk = 0;
  int  n_fail = 0;
  int  busy_cnt = 0;
  int  m_ptr = 0;
  bit  m_ovr = 1'b0;
  int  m_fs = -100000;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ram_we === 1'b1) begin
      wr_t e;
      e.cyc = cyc; e.a = ram_addr_w; e.d = ram_din;
      obs_q.push_back(e);
    end
    if (rd_data[0] === 1'b1) busy_cnt++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  // Model: fill occupies the 2**AW negedges following the one it was driven on
  function automatic bit m_busy();
    return (cyc >= m_fs + 1) && (cyc <= m_fs + DEPTH);
  endfunction

  function automatic logic [31:0] m_status();
    return (32'(m_ptr) << 16) | (32'(m_ovr) << 1) | 32'(m_busy());
  endfunction

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    bit  busy;
    wr_t e;
    @(negedge clk);
    cs = 1'b1; write = 1'b1; read = 1'($urandom_range(0, 1)); addr = a; wr_data = d;
    busy = FILL_EN && m_busy();
    case (a)
      2'd0: if (busy) m_ovr = 1'b1; else m_ptr = int'(d) & (DEPTH - 1);
      2'd1: if (busy) m_ovr = 1'b1;
            else begin
              e.cyc = cyc + 1; e.a = AW'(m_ptr); e.d = d[DW-1:0];
              exp_q.push_back(e);
              m_ptr = (m_ptr + 1) % DEPTH;
            end
      2'd2: if (FILL_EN) begin
              if (busy) m_ovr = 1'b1;
              else begin
                m_fs = cyc;
                for (int i = 0; i < DEPTH; i++) begin
                  e.cyc = cyc + 1 + i; e.a = AW'(i); e.d = d[DW-1:0];
                  exp_q.push_back(e);
                end
              end
            end
      default: m_ovr = 1'b0;
    endcase
  endtask

  task automatic bus_idle(input int n);
    repeat (n) begin
      @(negedge clk);
      cs = 1'b0; write = 1'b0; read = 1'b0;
    end
  endtask

  // Drive reset low at the current negedge; model drops writes not yet issued
  task automatic reset_assert();
    reset_n = 1'b0; cs = 1'b0; write = 1'b0;
    while (exp_q.size() > 0 && exp_q[$].cyc > cyc) void'(exp_q.pop_back());
    m_ptr = 0; m_ovr = 1'b0; m_fs = -100000;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset_assert();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    n_chk++;
    if (rd_data !== 32'h0) begin
      n_fail++; $display("FAIL reset_status: got %h expected %h", rd_data, 32'h0);
    end
    n_chk++;
    if ({ram_we, ram_addr_w, ram_din} !== '0) begin
      n_fail++; $display("FAIL reset_ram_port: got we %b addr %0d din %h expected all 0", ram_we, ram_addr_w, ram_din);
    end
    obs_q.delete();
    bus_idle(20);
    n_chk++;
    if (obs_q.size() !== 0) begin
      n_fail++; $display("FAIL reset_idle_we: got %0d writes expected 0", obs_q.size());
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_ptr_data();
    bus_wr(2'd0, 32'd5);
    bus_wr(2'd1, 32'hF00);
    bus_wr(2'd1, 32'h0F0);
    bus_idle(3);
    n_chk++;
    if (obs_q.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL ptr_data_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_chk++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL ptr_data_wr%0d: got cyc %0d addr %0d din %h expected cyc %0d addr %0d din %h",
                 i, obs_q[i].cyc, obs_q[i].a, obs_q[i].d, exp_q[i].cyc, exp_q[i].a, exp_q[i].d);
      end
    end
    obs_q.delete(); exp_q.delete();
    n_chk++;
    if (rd_data !== m_status()) begin
      n_fail++; $display("FAIL ptr_data_status: got %h expected %h", rd_data, m_status());
    end
  endtask

  task automatic test_wrap();
    bus_wr(2'd0, 32'd1023);
    bus_wr(2'd1, 32'h123);
    bus_wr(2'd1, 32'h456);
    bus_idle(3);
    n_chk++;
    if (obs_q.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL wrap_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_chk++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL wrap_wr%0d: got cyc %0d addr %0d din %h expected cyc %0d addr %0d din %h",
                 i, obs_q[i].cyc, obs_q[i].a, obs_q[i].d, exp_q[i].cyc, exp_q[i].a, exp_q[i].d);
      end
    end
    obs_q.delete(); exp_q.delete();
    n_chk++;
    if (rd_data !== m_status()) begin
      n_fail++; $display("FAIL wrap_status: got %h expected %h", rd_data, m_status());
    end
  endtask

  task automatic test_random();
    bit fill_used = 1'b0;
    for (int k = 0; k < 60; k++) begin
      int unsigned r = $urandom_range(0, 15);
      logic [1:0]  a;
      if (r < 5)                     a = 2'd0;
      else if (r < 12)               a = 2'd1;
      else if (r < 15 || fill_used)  a = 2'd3;
      else begin a = 2'd2; fill_used = 1'b1; end
      bus_wr(a, $urandom);
      if ($urandom_range(0, 3) == 0) bus_idle(1);
    end
    bus_idle(DEPTH + 4);
    n_chk++;
    if (obs_q.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL random_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_chk++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL random_wr%0d: got cyc %0d addr %0d din %h expected cyc %0d addr %0d din %h",
                 i, obs_q[i].cyc, obs_q[i].a, obs_q[i].d, exp_q[i].cyc, exp_q[i].a, exp_q[i].d);
      end
    end
    obs_q.delete(); exp_q.delete();
    n_chk++;
    if (rd_data !== m_status()) begin
      n_fail++; $display("FAIL random_status: got %h expected %h", rd_data, m_status());
    end
  endtask

`ifdef MOUSE_LOADER_FILL_EN
  task automatic test_fill();
    bus_wr(2'd0, 32'd77);
    bus_idle(1);
    busy_cnt = 0;
    bus_wr(2'd2, 32'hABC);
    bus_idle(200);
    n_chk++;
    if (rd_data !== m_status()) begin
      n_fail++; $display("FAIL fill_busy_status: got %h expected %h", rd_data, m_status());
    end
    bus_wr(2'd1, 32'h555);
    bus_idle(1);
    n_chk++;
    if (rd_data !== m_status()) begin
      n_fail++; $display("FAIL fill_overrun_status: got %h expected %h", rd_data, m_status());
    end
    bus_idle(DEPTH);
    n_chk++;
    if (rd_data !== m_status()) begin
      n_fail++; $display("FAIL fill_done_status: got %h expected %h", rd_data, m_status());
    end
    n_chk++;
    if (busy_cnt !== DEPTH) begin
      n_fail++; $display("FAIL fill_busy_cycles: got %0d expected %0d", busy_cnt, DEPTH);
    end
    n_chk++;
    if (obs_q.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL fill_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_chk++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL fill_wr%0d: got cyc %0d addr %0d din %h expected cyc %0d addr %0d din %h",
                 i, obs_q[i].cyc, obs_q[i].a, obs_q[i].d, exp_q[i].cyc, exp_q[i].a, exp_q[i].d);
      end
    end
    obs_q.delete(); exp_q.delete();
    bus_wr(2'd3, 32'd0);
    bus_idle(1);
    n_chk++;
    if (rd_data !== m_status()) begin
      n_fail++; $display("FAIL fill_ctrl_clear: got %h expected %h", rd_data, m_status());
    end
  endtask

  task automatic test_fill_reset();
    bit found = 1'b0;
    bus_wr(2'd0, 32'(1 + $urandom_range(0, 1000)));
    bus_wr(2'd2, $urandom);
    for (int k = 0; k < 2000 && !found; k++) begin
      @(negedge clk);
      cs = 1'b0; write = 1'b0;
      if (ram_we === 1'b1 && ram_addr_w === AW'(300)) found = 1'b1;
    end
    n_chk++;
    if (!found) begin
      n_fail++; $display("FAIL fill_reset_reach300: got no write at address 300 expected one within 2000 cycles");
    end
    reset_assert();
    @(negedge clk);
    n_chk++;
    if (ram_we !== 1'b0) begin
      n_fail++; $display("FAIL fill_reset_we: got %b expected 0", ram_we);
    end
    n_chk++;
    if (rd_data !== m_status()) begin
      n_fail++; $display("FAIL fill_reset_status: got %h expected %h", rd_data, m_status());
    end
    reset_n = 1'b1;
    bus_wr(2'd1, 32'h3C5);
    bus_idle(3);
    n_chk++;
    if (obs_q.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL fill_reset_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_chk++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL fill_reset_wr%0d: got cyc %0d addr %0d din %h expected cyc %0d addr %0d din %h",
                 i, obs_q[i].cyc, obs_q[i].a, obs_q[i].d, exp_q[i].cyc, exp_q[i].a, exp_q[i].d);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask
`else
  task automatic test_fill_disabled();
    bus_wr(2'd0, 32'd9);
    bus_wr(2'd2, 32'hABC);
    bus_wr(2'd1, 32'h777);
    bus_idle(20);
    n_chk++;
    if (obs_q.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL nofill_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_chk++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL nofill_wr%0d: got cyc %0d addr %0d din %h expected cyc %0d addr %0d din %h",
                 i, obs_q[i].cyc, obs_q[i].a, obs_q[i].d, exp_q[i].cyc, exp_q[i].a, exp_q[i].d);
      end
    end
    obs_q.delete(); exp_q.delete();
    n_chk++;
    if (rd_data !== m_status()) begin
      n_fail++; $display("FAIL nofill_status: got %h expected %h", rd_data, m_status());
    end
  endtask
`endif

  initial begin
    test_reset();
    test_ptr_data();
    test_wrap();
`ifdef MOUSE_LOADER_FILL_EN
    test_fill();
    test_fill_reset();
`else
    test_fill_disabled();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
